// File: rtl/dmem_wait_ctrl_pkg.sv
// Shared types, widths and address helper for the wait-state data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Widths for the default geometry (32-bit words, 64 entries).
  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 64;
  localparam int BYTES      = DEF_DATA_W / 8;
  localparam int IDX_W      = $clog2(DEF_DEPTH);
  localparam int CNT_W      = 4;

  // Byte address to word index relative to base; 32-bit wrapping subtract.
  function automatic logic [31:0] addr_to_index(input logic [31:0] addr,
                                                input logic [31:0] base,
                                                input int          shift);
    return (addr - base) >> shift;
  endfunction

endpackage

// File: rtl/dmem_wait_ctrl_if.sv
// MEM-stage <-> data memory handshake bundle.
interface dmem_wait_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              mem_r_en;
  logic              mem_w_en;
  logic [31:0]       alu_res;
  logic [DATA_W-1:0] val_rm;
  logic [DATA_W-1:0] out;
  logic              ready;
  logic              err;

  modport master (
    output mem_r_en, mem_w_en, alu_res, val_rm,
    input  out, ready, err
  );

  modport slave (
    input  mem_r_en, mem_w_en, alu_res, val_rm,
    output out, ready, err
  );
endinterface

// File: rtl/dmem_wait_ctrl_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage has no reset; clearing it would defeat RAM inference and contents survive rst.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Multi-cycle MEM-stage data memory with ready/stall handshake.
// Optional range/alignment checking is enabled by defining DMEM_RANGE_CHECK_EN.
module dmem_wait_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 64,
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  dmem_wait_ctrl_if.slave  bus
);

  localparam int N_BYTES = DATA_W / 8;
  localparam int OFS_W   = $clog2(N_BYTES);
  localparam int AW      = $clog2(DEPTH);
  localparam logic [31:0] BASE = 32'(BASE_ADDR);
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]      idx_q;
  logic [DATA_W-1:0]  data_q;
  logic               wr_q;
  logic               err_q;

  logic               req;
  logic [AW-1:0]      req_idx;
  logic               range_err;
  logic               ready;

  logic [AW-1:0]      cur_idx;
  logic [DATA_W-1:0]  cur_data;
  logic               cur_wr;
  logic               cur_err;
  logic               mem_we;
  logic [DATA_W-1:0]  rd_data;

  assign req     = bus.mem_r_en | bus.mem_w_en;
  assign req_idx = AW'(addr_to_index(bus.alu_res, BASE, OFS_W));

`ifdef DMEM_RANGE_CHECK_EN
  localparam logic [31:0] LIMIT = 32'(BASE_ADDR + DEPTH * N_BYTES);
  assign range_err = (bus.alu_res < BASE) || (bus.alu_res >= LIMIT) ||
                     ((bus.alu_res & 32'(N_BYTES - 1)) != 32'd0);
`else
  assign range_err = 1'b0;
`endif

  // In IDLE the request is live on the inputs; afterwards the latched copy rules.
  assign cur_idx  = (state_q == IDLE) ? req_idx      : idx_q;
  assign cur_data = (state_q == IDLE) ? bus.val_rm   : data_q;
  assign cur_wr   = (state_q == IDLE) ? bus.mem_w_en : wr_q;
  assign cur_err  = (state_q == IDLE) ? range_err    : err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b1;
    case (state_q)
      IDLE: begin
        ready = ~req;
        if (req) begin
          state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        ready = 1'b0;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Commit on the edge entering DONE; a reset on that edge discards the write.
  assign mem_we = rst && (state_q != DONE) && (state_d == DONE) && cur_wr && !cur_err;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req) begin
        wr_q  <= bus.mem_w_en;
        err_q <= range_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && req) begin
      idx_q  <= req_idx;
      data_q <= bus.val_rm;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (cur_idx),
    .wdata (cur_data),
    .raddr (idx_q),
    .rdata (rd_data)
  );

  assign bus.ready = ready;
  assign bus.out   = (state_q == DONE && !wr_q && !err_q) ? rd_data : '0;
`ifdef DMEM_RANGE_CHECK_EN
  assign bus.err   = (state_q == DONE) && err_q;
`else
  assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed bench for dmem_wait_ctrl: WAIT_CYCLES=4 and WAIT_CYCLES=0 instances.
module tb_dmem_wait_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  dmem_wait_ctrl_if #(.DATA_W(32)) w4_if ();
  dmem_wait_ctrl_if #(.DATA_W(32)) w0_if ();

  dmem_wait_ctrl #(.DATA_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(4)) u_w4 (
    .clk (clk),
    .rst (rst),
    .bus (w4_if.slave)
  );

  dmem_wait_ctrl #(.DATA_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)) u_w0 (
    .clk (clk),
    .rst (rst),
    .bus (w0_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      w0_if.mem_r_en = rd; w0_if.mem_w_en = wr; w0_if.alu_res = a; w0_if.val_rm = d;
    end else begin
      w4_if.mem_r_en = rd; w4_if.mem_w_en = wr; w4_if.alu_res = a; w4_if.val_rm = d;
    end
  endtask

  // Called 1 time unit after a rising edge. Holds the request until ready,
  // reports DONE-cycle out/err and how many cycles ready stayed low.
  task automatic access(input bit sel, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] got, output logic got_err, output int lows);
    logic rdy;
    drive(sel, rd, wr, a, d);
    lows = 0;
    #1;
    rdy = sel ? w0_if.ready : w4_if.ready;
    while (rdy !== 1'b1 && lows < 40) begin
      lows++;
      @(posedge clk); #2;
      rdy = sel ? w0_if.ready : w4_if.ready;
    end
    check("access_timeout", 32'(lows < 40), 32'd1);
    got     = sel ? w0_if.out : w4_if.out;
    got_err = sel ? w0_if.err : w4_if.err;
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  logic [31:0] got;
  logic        got_err;
  int          lows;

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);

    // 1. reset
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #2;
    check("reset_ready", 32'(w4_if.ready), 32'd1);
    check("reset_out",   w4_if.out,        32'd0);
    check("reset_err",   32'(w4_if.err),   32'd0);
    check("reset_ready_w0", 32'(w0_if.ready), 32'd1);
    #1;

    // 2. write then read @1028, 4 wait states
    access(1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, got, got_err, lows);
    check("wr1028_lows", 32'(lows), 32'd5);
    check("wr1028_out",  got,       32'd0);
    access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, got, got_err, lows);
    check("rd1028_lows", 32'(lows), 32'd5);
    check("rd1028_out",  got,       32'hDEADBEEF);
    check("rd1028_err",  32'(got_err), 32'd0);
    #1;
    check("idle_out", w4_if.out, 32'd0);
    check("idle_ready", 32'(w4_if.ready), 32'd1);
    #1 @(posedge clk); #1;

    // 3. zero wait states
    access(1'b1, 1'b0, 1'b1, 32'd1024, 32'h00001234, got, got_err, lows);
    check("w0_wr_lows", 32'(lows), 32'd1);
    check("w0_wr_out",  got,       32'd0);
    access(1'b1, 1'b1, 1'b0, 32'd1024, 32'h0, got, got_err, lows);
    check("w0_rd_lows", 32'(lows), 32'd1);
    check("w0_rd_out",  got,       32'h00001234);

    // 4. reset aborts a pending write
    access(1'b0, 1'b0, 1'b1, 32'd1024, 32'h11, got, got_err, lows);
    check("wr11_lows", 32'(lows), 32'd5);
    drive(1'b0, 1'b0, 1'b1, 32'd1024, 32'h22);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1 check("abort_in_wait_ready", 32'(w4_if.ready), 32'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("abort_ready", 32'(w4_if.ready), 32'd1);
    check("abort_out",   w4_if.out,        32'd0);
    #1 @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, got, got_err, lows);
    check("abort_rd_out", got, 32'h11);

    // 5. read and write together count as a write
    access(1'b0, 1'b1, 1'b1, 32'd1032, 32'h00005A5A, got, got_err, lows);
    check("rw_out",  got,       32'd0);
    check("rw_lows", 32'(lows), 32'd5);
    access(1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, got, got_err, lows);
    check("rw_rd_out", got, 32'h00005A5A);

    // 6. out-of-range write @1280
    access(1'b0, 1'b0, 1'b1, 32'd1280, 32'hCAFEF00D, got, got_err, lows);
    check("oor_lows", 32'(lows), 32'd5);
`ifdef DMEM_RANGE_CHECK_EN
    check("oor_err", 32'(got_err), 32'd1);
    #1 check("oor_err_pulse", 32'(w4_if.err), 32'd0);
    #1 @(posedge clk); #1;
    access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, got, got_err, lows);
    check("oor_rd_out", got, 32'h11);
    check("oor_rd_err", 32'(got_err), 32'd0);
`else
    check("oor_err", 32'(got_err), 32'd0);
    access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, got, got_err, lows);
    check("oor_alias_out", got, 32'hCAFEF00D);
    check("oor_rd_err", 32'(got_err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
